// File: rtl/adiv5_memap.sv
// adiv5_memap: single-word MEM-AP access engine feeding the ADIv5 mux FIFOs.
// Issues SELECT/TAR/DRW/RDBUFF per access, caching SELECT and TAR.
module adiv5_memap #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 10
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [7:0]  APSEL,
  input  logic        FLUSH,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic [1:0]  RSP_ERR,
  output logic [35:0] ADIv5_WRDATA,
  output logic        ADIv5_WREN,
  input  logic        ADIv5_WRFULL,
  input  logic [34:0] ADIv5_RDDATA,
  output logic        ADIv5_RDEN,
  input  logic        ADIv5_RDEMPTY
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] SEL_CMD = 4'd1;
  localparam logic [3:0] SEL_RSP = 4'd2;
  localparam logic [3:0] TAR_CMD = 4'd3;
  localparam logic [3:0] TAR_RSP = 4'd4;
  localparam logic [3:0] DRW_CMD = 4'd5;
  localparam logic [3:0] DRW_RSP = 4'd6;
  localparam logic [3:0] BUF_CMD = 4'd7;
  localparam logic [3:0] BUF_RSP = 4'd8;
  localparam logic [3:0] DONE    = 4'd9;

  logic [3:0]    state;
  logic [3:0]    nxt;
  logic [7:0]    ap;
  logic [29:0]   addr;
  logic [31:0]   wdata;
  logic          wr;
  logic          sel_vld;
  logic          tar_vld;
  logic [7:0]    sel_ap;
  logic [29:0]   tar_addr;
  logic [TW-1:0] cnt;
  logic [1:0]    orphan;

  logic cmd_st;
  logic rsp_st;
  logic accept;
  logic pop;
  logic discard;
  logic ok;
  logic bad;
  logic tmo;
  logic sel_hit_in;
  logic tar_hit_in;
  logic tar_hit;
  logic unused_ok;

  assign unused_ok = ^REQ_ADDR[1:0];

  assign cmd_st = (state == SEL_CMD) || (state == TAR_CMD) ||
                  (state == DRW_CMD) || (state == BUF_CMD);
  assign rsp_st = (state == SEL_RSP) || (state == TAR_RSP) ||
                  (state == DRW_RSP) || (state == BUF_RSP);

  assign accept = (state == IDLE) && REQ_VALID && REQ_READY;

  // orphan counts abandoned commands whose late responses must be dropped
  assign pop     = !ADIv5_RDEMPTY && (rsp_st || orphan != 2'd0);
  assign discard = pop && (orphan != 2'd0);
  assign ok      = pop && (orphan == 2'd0) && (ADIv5_RDDATA[34:32] == 3'b000);
  assign bad     = pop && (orphan == 2'd0) && (ADIv5_RDDATA[34:32] != 3'b000);
  assign tmo     = rsp_st && ADIv5_RDEMPTY && (cnt == TW'(TIMEOUT - 1));

  assign sel_hit_in = sel_vld && !FLUSH && (sel_ap == APSEL);
  assign tar_hit_in = tar_vld && !FLUSH && (tar_addr == REQ_ADDR[31:2]);
  assign tar_hit    = tar_vld && !FLUSH && (tar_addr == addr);

  assign ADIv5_RDEN = pop;
  assign ADIv5_WREN = cmd_st && !ADIv5_WRFULL;
  assign RSP_VALID  = (state == DONE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:
        if (accept)
          nxt = !sel_hit_in ? SEL_CMD :
                !tar_hit_in ? TAR_CMD : DRW_CMD;
      SEL_CMD: if (!ADIv5_WRFULL) nxt = SEL_RSP;
      TAR_CMD: if (!ADIv5_WRFULL) nxt = TAR_RSP;
      DRW_CMD: if (!ADIv5_WRFULL) nxt = DRW_RSP;
      BUF_CMD: if (!ADIv5_WRFULL) nxt = BUF_RSP;
      SEL_RSP:
        if (bad || tmo) nxt = DONE;
        else if (ok)    nxt = tar_hit ? DRW_CMD : TAR_CMD;
      TAR_RSP:
        if (bad || tmo) nxt = DONE;
        else if (ok)    nxt = DRW_CMD;
      DRW_RSP:
        if (bad || tmo) nxt = DONE;
        else if (ok)    nxt = wr ? DONE : BUF_CMD;
      BUF_RSP:
        if (bad || tmo || ok) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ADIv5_WRDATA = '0;
    case (state)
      SEL_CMD: ADIv5_WRDATA = {1'b0, 1'b0, 2'b10, ap, 24'h0};
      TAR_CMD: ADIv5_WRDATA = {1'b1, 1'b0, 2'b01, addr, 2'b00};
      DRW_CMD: ADIv5_WRDATA = {1'b1, ~wr, 2'b11, wr ? wdata : 32'h0};
      BUF_CMD: ADIv5_WRDATA = {1'b0, 1'b1, 2'b11, 32'h0};
      default: ADIv5_WRDATA = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= IDLE;
      REQ_READY <= 1'b0;
      ap        <= '0;
      addr      <= '0;
      wdata     <= '0;
      wr        <= 1'b0;
      sel_vld   <= 1'b0;
      tar_vld   <= 1'b0;
      sel_ap    <= '0;
      tar_addr  <= '0;
      cnt       <= '0;
      orphan    <= '0;
      RSP_RDATA <= '0;
      RSP_ERR   <= '0;
    end else begin
      state     <= nxt;
      REQ_READY <= (nxt == IDLE);
      if (accept) begin
        ap    <= APSEL;
        addr  <= REQ_ADDR[31:2];
        wdata <= REQ_WDATA;
        wr    <= REQ_WRITE;
      end
      if (cmd_st)
        cnt <= '0;
      else if (rsp_st && ADIv5_RDEMPTY)
        cnt <= cnt + TW'(1);
      if (tmo && orphan != 2'd3)
        orphan <= orphan + 2'd1;
      else if (discard)
        orphan <= orphan - 2'd1;
      // FLUSH takes priority over a same-cycle cache fill
      if (FLUSH || bad || tmo) begin
        sel_vld <= 1'b0;
        tar_vld <= 1'b0;
      end else begin
        if (ok && state == SEL_RSP) begin
          sel_vld <= 1'b1;
          sel_ap  <= ap;
        end
        if (ok && state == TAR_RSP) begin
          tar_vld  <= 1'b1;
          tar_addr <= addr;
        end
      end
      if (bad) begin
        RSP_ERR   <= 2'd1;
        RSP_RDATA <= '0;
      end else if (tmo) begin
        RSP_ERR   <= 2'd2;
        RSP_RDATA <= '0;
      end else if (ok && state == DRW_RSP && wr) begin
        RSP_ERR   <= 2'd0;
        RSP_RDATA <= '0;
      end else if (ok && state == BUF_RSP) begin
        RSP_ERR   <= 2'd0;
        RSP_RDATA <= ADIv5_RDDATA[31:0];
      end
    end
  end

endmodule

// File: tb/tb_adiv5_memap.sv
// tb_adiv5_memap: directed vectors plus corner sequences for adiv5_memap.
// A small PHY model answers each pushed command through a response queue.
module tb_adiv5_memap;

  localparam int TIMEOUT = 1024;
  localparam int LIM     = 3000;

  logic        clk = 1'b0;
  logic        RESETn;
  logic [7:0]  APSEL;
  logic        FLUSH;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_ERR;
  logic [35:0] ADIv5_WRDATA;
  logic        ADIv5_WREN;
  logic        ADIv5_WRFULL;
  logic [34:0] ADIv5_RDDATA;
  logic        ADIv5_RDEN;
  logic        ADIv5_RDEMPTY;

  adiv5_memap #(.TIMEOUT(TIMEOUT), .TW(10)) dut (
    .CLK(clk),
    .RESETn(RESETn),
    .APSEL(APSEL),
    .FLUSH(FLUSH),
    .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY),
    .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID),
    .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR),
    .ADIv5_WRDATA(ADIv5_WRDATA),
    .ADIv5_WREN(ADIv5_WREN),
    .ADIv5_WRFULL(ADIv5_WRFULL),
    .ADIv5_RDDATA(ADIv5_RDDATA),
    .ADIv5_RDEN(ADIv5_RDEN),
    .ADIv5_RDEMPTY(ADIv5_RDEMPTY)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [35:0] cmd_log[$];
  logic [34:0] rsp_q[$];
  logic        auto_rsp  = 1'b1;
  logic        err_en    = 1'b0;
  logic [3:0]  err_cmd   = 4'h0;
  logic [31:0] rdbuf_val = 32'h0;
  int          wren_full = 0;

  function automatic logic [34:0] mk_rsp(input logic [35:0] c);
    logic [2:0]  st;
    logic [31:0] d;
    st = (err_en && c[35:32] == err_cmd) ? 3'b001 : 3'b000;
    d  = (c[35:32] == 4'h7) ? rdbuf_val : 32'h0BAD0BAD;
    return {st, d};
  endfunction

  always @(posedge clk) begin
    if (ADIv5_WREN && ADIv5_WRFULL) wren_full++;
    if (ADIv5_RDEN && rsp_q.size() > 0) rsp_q.delete(0);
    if (ADIv5_WREN && !ADIv5_WRFULL) begin
      cmd_log.push_back(ADIv5_WRDATA);
      if (auto_rsp) rsp_q.push_back(mk_rsp(ADIv5_WRDATA));
    end
    #1;
    ADIv5_RDEMPTY = (rsp_q.size() == 0);
    ADIv5_RDDATA  = (rsp_q.size() > 0) ? rsp_q[0] : '0;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic             flush;
    logic             wr;
    logic [7:0]       ap;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      rdbuf;
    int               ncmd;
    logic [3:0][35:0] c;
    logic [1:0]       err;
    logic [31:0]      rdata;
    int               lat;
  } vec_t;

  function automatic vec_t mkv(input logic fl, input logic wr,
    input logic [7:0] ap, input logic [31:0] a, input logic [31:0] d,
    input logic [31:0] rb, input int n,
    input logic [35:0] c0, input logic [35:0] c1,
    input logic [35:0] c2, input logic [35:0] c3,
    input logic [1:0] e, input logic [31:0] rd, input int lat);
    vec_t v;
    v.flush = fl; v.wr = wr; v.ap = ap; v.addr = a; v.wdata = d;
    v.rdbuf = rb; v.ncmd = n; v.c = {c3, c2, c1, c0};
    v.err = e; v.rdata = rd; v.lat = lat;
    return v;
  endfunction

  task automatic start_req(input logic wr, input logic [7:0] ap,
                           input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    REQ_WRITE = wr; APSEL = ap; REQ_ADDR = a; REQ_WDATA = d;
    REQ_VALID = 1'b1;
    n = 0;
    while (!REQ_READY && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req accepted", REQ_READY, 1);
    @(negedge clk);
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!RSP_VALID && cyc < LIM) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_valid seen", RSP_VALID, 1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    logic [35:0] got;
    if (v.flush) begin
      @(negedge clk); FLUSH = 1'b1;
      @(negedge clk); FLUSH = 1'b0;
    end
    rdbuf_val = v.rdbuf;
    cmd_log.delete();
    start_req(v.wr, v.ap, v.addr, v.wdata);
    wait_rsp(cyc);
    chk({tag, " ncmd"}, cmd_log.size(), v.ncmd);
    for (int i = 0; i < v.ncmd; i++) begin
      got = (i < cmd_log.size()) ? cmd_log[i] : '1;
      chk($sformatf("%s cmd%0d", tag, i), got, v.c[i]);
    end
    chk({tag, " err"}, RSP_ERR, v.err);
    chk({tag, " rdata"}, RSP_RDATA, v.rdata);
    if (v.lat != 0) chk({tag, " latency"}, cyc + 2, v.lat);
    @(negedge clk);
    chk({tag, " rsp one cycle"}, RSP_VALID, 0);
  endtask

  vec_t tbl[8];
  vec_t v;
  int   cyc;
  int   n;

  initial begin
    tbl[0] = mkv(0, 1, 8'h00, 32'h2000_0000, 32'hDEAD_BEEF, 0, 3,
                 36'h2_0000_0000, 36'h9_2000_0000, 36'hB_DEAD_BEEF, 0,
                 2'd0, 32'h0, 8);
    tbl[1] = mkv(0, 1, 8'h00, 32'h2000_0000, 32'hCAFE_F00D, 0, 1,
                 36'hB_CAFE_F00D, 0, 0, 0, 2'd0, 32'h0, 4);
    tbl[2] = mkv(0, 0, 8'h00, 32'h2000_0004, 32'hFFFF_FFFF, 32'h1234_5678, 3,
                 36'h9_2000_0004, 36'hF_0000_0000, 36'h7_0000_0000, 0,
                 2'd0, 32'h1234_5678, 8);
    tbl[3] = mkv(0, 0, 8'h00, 32'h2000_0006, 32'h0, 32'hA5A5_0001, 2,
                 36'hF_0000_0000, 36'h7_0000_0000, 0, 0,
                 2'd0, 32'hA5A5_0001, 6);
    tbl[4] = mkv(0, 1, 8'h01, 32'h2000_0004, 32'h0000_0001, 0, 2,
                 36'h2_0100_0000, 36'hB_0000_0001, 0, 0, 2'd0, 32'h0, 6);
    tbl[5] = mkv(1, 1, 8'h01, 32'h2000_0004, 32'h0000_0002, 0, 3,
                 36'h2_0100_0000, 36'h9_2000_0004, 36'hB_0000_0002, 0,
                 2'd0, 32'h0, 8);
    tbl[6] = mkv(0, 1, 8'h01, 32'h2000_0004, 32'h0000_0003, 0, 1,
                 36'hB_0000_0003, 0, 0, 0, 2'd0, 32'h0, 4);
    tbl[7] = mkv(0, 0, 8'h80, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 4,
                 36'h2_8000_0000, 36'h9_FFFF_FFFC, 36'hF_0000_0000,
                 36'h7_0000_0000, 2'd0, 32'hFFFF_FFFF, 10);

    RESETn = 1'b0; APSEL = '0; FLUSH = 1'b0; REQ_VALID = 1'b0;
    REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
    ADIv5_WRFULL = 1'b0; ADIv5_RDDATA = '0; ADIv5_RDEMPTY = 1'b1;
    #12;
    chk("reset req_ready", REQ_READY, 0);
    chk("reset rsp_valid", RSP_VALID, 0);
    chk("reset rsp_rdata", RSP_RDATA, 0);
    chk("reset rsp_err", RSP_ERR, 0);
    chk("reset wren", ADIv5_WREN, 0);
    chk("reset rden", ADIv5_RDEN, 0);
    chk("reset wrdata", ADIv5_WRDATA, 0);
    @(negedge clk); RESETn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle req_ready", REQ_READY, 1);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // TAR fault: no DRW, caches dropped
    err_en = 1'b1; err_cmd = 4'h9;
    v = mkv(0, 1, 8'h80, 32'h0000_1000, 32'h11, 0, 1,
            36'h9_0000_1000, 0, 0, 0, 2'd1, 32'h0, 0);
    run_vec(v, "tar_fault");
    err_en = 1'b0;
    v = mkv(0, 1, 8'h80, 32'h0000_1000, 32'h11, 0, 3,
            36'h2_8000_0000, 36'h9_0000_1000, 36'hB_0000_0011, 0,
            2'd0, 32'h0, 8);
    run_vec(v, "after_fault");

    // no response: timeout TIMEOUT cycles after entering DRW_RSP
    auto_rsp = 1'b0;
    v = mkv(0, 1, 8'h80, 32'h0000_1000, 32'h5, 0, 1,
            36'hB_0000_0005, 0, 0, 0, 2'd2, 32'h0, TIMEOUT + 3);
    run_vec(v, "timeout");
    auto_rsp = 1'b1;
    rsp_q.push_back({3'b000, 32'h0BAD0BAD});
    repeat (4) @(negedge clk);
    chk("late rsp drained", rsp_q.size(), 0);
    v = mkv(0, 0, 8'h80, 32'h0000_1000, 32'h0, 32'h600D_F00D, 4,
            36'h2_8000_0000, 36'h9_0000_1000, 36'hF_0000_0000,
            36'h7_0000_0000, 2'd0, 32'h600D_F00D, 10);
    run_vec(v, "after_timeout");

    // command FIFO full for 20 cycles
    cmd_log.delete();
    wren_full = 0;
    @(negedge clk); ADIv5_WRFULL = 1'b1;
    start_req(1'b1, 8'h80, 32'h0000_1000, 32'h7);
    repeat (20) @(negedge clk);
    chk("full no push", cmd_log.size(), 0);
    ADIv5_WRFULL = 1'b0;
    wait_rsp(cyc);
    chk("full wren while full", wren_full, 0);
    chk("full single push", cmd_log.size(), 1);
    chk("full cmd", cmd_log.size() > 0 ? cmd_log[0] : '1, 36'hB_0000_0007);
    chk("full err", RSP_ERR, 0);

    // async reset while waiting in DRW_RSP
    auto_rsp = 1'b0;
    cmd_log.delete();
    start_req(1'b1, 8'h80, 32'h0000_1000, 32'h9);
    n = 0;
    while (cmd_log.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drw before reset", cmd_log.size(), 1);
    @(negedge clk);
    #2 RESETn = 1'b0;
    #1;
    chk("mid reset req_ready", REQ_READY, 0);
    chk("mid reset rsp_valid", RSP_VALID, 0);
    chk("mid reset rsp_rdata", RSP_RDATA, 0);
    chk("mid reset rsp_err", RSP_ERR, 0);
    chk("mid reset wren", ADIv5_WREN, 0);
    chk("mid reset rden", ADIv5_RDEN, 0);
    chk("mid reset wrdata", ADIv5_WRDATA, 0);
    rsp_q.delete();
    auto_rsp = 1'b1;
    @(negedge clk); RESETn = 1'b1;
    v = mkv(0, 1, 8'h80, 32'h0000_1000, 32'h9, 0, 3,
            36'h2_8000_0000, 36'h9_0000_1000, 36'hB_0000_0009, 0,
            2'd0, 32'h0, 8);
    run_vec(v, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
